multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: opcode  input  6  instruction bits 31-26 from the instruction register.
REQ-004 SHALL provide: funct  input  6  instruction bits 5-0 from the instruction register.
REQ-005 SHALL provide: mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL provide: pcwrite, pcwritecond, pcwritecondne  output  1 each  unconditional, beq-gated and bne-gated PC load.
REQ-007 SHALL provide: iord, memread, memwrite, irwrite, regwrite, alusrca  output  1 each  usual multicycle datapath strobes.
REQ-008 SHALL provide: regdst, memtoreg, alusrcb, aluop, pcsource  output  2 each  mux selects and ALU op class.
REQ-009 SHALL provide: state  output  4  current state code; instr_done  output  1  last cycle of an instruction.

Function
REQ-010 SHALL be a Moore FSM; outputs decode from the state register and mem_ready only.
REQ-011 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, BEQ, BNE, ADDIEX, ADDIWB, JUMP, JAL, JR, HALT.
REQ-012 FETCH SHALL drive memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
REQ-013 In FETCH, irwrite and pcwrite SHALL be 1 only while mem_ready=1; FETCH -> DECODE only when mem_ready=1, otherwise hold.
REQ-014 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut).
REQ-015 DECODE transitions: 100011/101011 -> MEMADR; 000000 with funct 001000 -> JR; other 000000 -> REXEC; 000100 -> BEQ; 000101 -> BNE; 001000 -> ADDIEX; 000010 -> JUMP; 000011 -> JAL; any other opcode -> HALT.
REQ-016 MEMADR (alusrca=1, alusrcb=10, aluop=00) SHALL go to MEMRD for lw and MEMWR for sw.
REQ-017 MEMRD (memread=1, iord=1) and MEMWR (memwrite=1, iord=1) SHALL hold until mem_ready=1; memwrite SHALL stay high for every waiting cycle.
REQ-018 MEMRD -> MEMWB; MEMWB drives regwrite=1, regdst=00, memtoreg=01.
REQ-019 REXEC drives alusrca=1, alusrcb=00, aluop=10, then goes to RWB; RWB drives regwrite=1, regdst=01, memtoreg=00.
REQ-020 BEQ drives alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01.
REQ-021 BNE drives the same outputs as BEQ, except pcwritecondne=1 in place of pcwritecond.
REQ-022 ADDIEX drives alusrca=1, alusrcb=10, aluop=00; ADDIWB drives regwrite=1, regdst=00, memtoreg=00.
REQ-023 JUMP drives pcwrite=1, pcsource=10; JR drives pcwrite=1, pcsource=11.
REQ-024 JAL drives pcwrite=1, pcsource=10, regwrite=1, regdst=10, memtoreg=10.
REQ-025 MEMWB, MEMWR (on its exit cycle), RWB, BEQ, BNE, ADDIWB, JUMP, JAL and JR SHALL assert instr_done=1 and go to FETCH.
REQ-026 HALT SHALL be absorbing, with all strobes 0 and instr_done=0; only reset exits it.
REQ-027 Latency without wait states SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jal/jr 3 cycles.
REQ-028 Every output not listed for a state SHALL be 0, and every select not listed SHALL be 00.

Reset
REQ-029 reset=1 SHALL force state=FETCH asynchronously.
REQ-030 While reset=1, all write/read strobes and instr_done SHALL be 0, independent of state.
REQ-031 Reset asserted mid-instruction (including a MEMWR wait) SHALL abort the instruction with no further strobes.
REQ-032 The first FETCH SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-033 State codes, opcode/funct constants and the aluop/pcsource encodings SHALL live in a shared package, mc_defs, shared with the ALU control unit.
REQ-034 Output decoding SHALL be one combinational sub-module, mc_outdec (state, mem_ready, reset in; strobes out); the FSM register and next-state logic stay in the top module.

Verification
REQ-035 Reset, then opcode=100011 with mem_ready=1 constantly -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 only in MEMWB; instr_done on cycle 5.
REQ-036 opcode=101011, mem_ready=0 for 3 MEMWR cycles then 1 -> memwrite high for 4 cycles, then FETCH; instr_done on cycle 7.
REQ-037 opcode=000000, funct=001000 -> DECODE->JR, pcwrite=1, pcsource=11, regwrite=0.
REQ-038 opcode=000101 -> BNE with pcwritecondne=1, pcwritecond=0, aluop=01; 3 cycles total.
REQ-039 opcode=111111 -> HALT with all strobes 0 for 10 cycles; reset pulse -> FETCH.
REQ-040 reset asserted between clk edges during MEMWR -> memwrite drops immediately, state=FETCH.

Source files
------------

// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - shared encodings for the multicycle control unit and ALU control
//
// Contents:
//   mc_state_t       4-bit FSM state codes (visible on the controller's state port)
//   OP_* / FN_*      opcode and funct field constants
//   ALUOP_*          ALU operation class handed to the ALU control unit
//   PCSRC_*          next-PC source mux selects
//   REGDST_*, MEMTOREG_*, ALUSRCB_*  datapath mux selects
//   mc_ctrl_t        bundle of every control output of the controller
//   decode_dispatch  DECODE-state dispatch from opcode/funct to the first
//                    instruction-specific state
package mc_defs;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_JR     = 4'd14,
        S_HALT   = 4'd15
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALU operation class: add for address/PC arithmetic, subtract for
    // branch compare, or let the ALU control unit decode funct.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source: ALU result (PC+4), ALUOut (branch target),
    // jump target field, register operand (jr).
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    localparam logic [1:0] ALUSRCB_REG    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       pcwritecondne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       instr_done;
    } mc_ctrl_t;

    // Unknown opcodes park the machine in HALT rather than guessing.
    function automatic mc_state_t decode_dispatch(input logic [5:0] opcode,
                                                  input logic [5:0] funct);
        mc_state_t nxt;
        case (opcode)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = (funct == FN_JR) ? S_JR : S_REXEC;
            OP_BEQ:       nxt = S_BEQ;
            OP_BNE:       nxt = S_BNE;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            OP_JAL:       nxt = S_JAL;
            default:      nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - Moore output decoder for the multicycle controller
//
// Ports:
//   state      in   current FSM state
//   mem_ready  in   memory access completes this cycle
//   reset      in   controller reset; forces every control output to 0
//   ctrl       out  all strobes, mux selects and instr_done
//
// Purely combinational. mem_ready only qualifies the FETCH commit strobes
// and the MEMWR completion flag; everything else is a function of state.
module mc_outdec
    import mc_defs::*;
(
    input  mc_state_t state,
    input  logic      mem_ready,
    input  logic      reset,
    output mc_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        // Gating on reset makes strobes die the moment reset rises, even
        // though the state register itself only clears on that same edge.
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctrl.memread  = 1'b1;
                    ctrl.alusrcb  = ALUSRCB_FOUR;
                    ctrl.aluop    = ALUOP_ADD;
                    ctrl.pcsource = PCSRC_ALU;
                    // IR and PC commit only on the cycle the fetch data lands.
                    ctrl.irwrite  = mem_ready;
                    ctrl.pcwrite  = mem_ready;
                end
                S_DECODE: begin
                    // Precompute branch target into ALUOut speculatively.
                    ctrl.alusrcb = ALUSRCB_BRANCH;
                    ctrl.aluop   = ALUOP_ADD;
                end
                S_MEMADR: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = ALUSRCB_IMM;
                    ctrl.aluop   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.memread = 1'b1;
                    ctrl.iord    = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.regdst     = REGDST_RT;
                    ctrl.memtoreg   = MEMTOREG_MEM;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    // memwrite is held through every wait cycle; the store
                    // finishes on the cycle memory accepts it.
                    ctrl.memwrite   = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_ready;
                end
                S_REXEC: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = ALUSRCB_REG;
                    ctrl.aluop   = ALUOP_FUNCT;
                end
                S_RWB: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.regdst     = REGDST_RD;
                    ctrl.memtoreg   = MEMTOREG_ALU;
                    ctrl.instr_done = 1'b1;
                end
                S_BEQ, S_BNE: begin
                    ctrl.alusrca       = 1'b1;
                    ctrl.alusrcb       = ALUSRCB_REG;
                    ctrl.aluop         = ALUOP_SUB;
                    ctrl.pcsource      = PCSRC_ALUOUT;
                    ctrl.pcwritecond   = (state == S_BEQ);
                    ctrl.pcwritecondne = (state == S_BNE);
                    ctrl.instr_done    = 1'b1;
                end
                S_ADDIEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = ALUSRCB_IMM;
                    ctrl.aluop   = ALUOP_ADD;
                end
                S_ADDIWB: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.regdst     = REGDST_RT;
                    ctrl.memtoreg   = MEMTOREG_ALU;
                    ctrl.instr_done = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pcwrite    = 1'b1;
                    ctrl.pcsource   = PCSRC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                S_JAL: begin
                    // Link register gets the already-incremented PC.
                    ctrl.pcwrite    = 1'b1;
                    ctrl.pcsource   = PCSRC_JUMP;
                    ctrl.regwrite   = 1'b1;
                    ctrl.regdst     = REGDST_RA;
                    ctrl.memtoreg   = MEMTOREG_PC;
                    ctrl.instr_done = 1'b1;
                end
                S_JR: begin
                    ctrl.pcwrite    = 1'b1;
                    ctrl.pcsource   = PCSRC_REG;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;  // HALT: fully quiet
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style main control FSM
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset, returns to FETCH
//   opcode, funct  in   instruction register fields [31:26] and [5:0]
//   mem_ready      in   memory access completes this cycle
//   pcwrite, pcwritecond, pcwritecondne            out  PC load enables
//   iord, memread, memwrite, irwrite, regwrite, alusrca  out  datapath strobes
//   regdst, memtoreg, alusrcb, aluop, pcsource     out  2-bit selects
//   state          out  current state code
//   instr_done     out  last cycle of the current instruction
//
// The state register and next-state logic live here; all outputs come from
// mc_outdec as a Moore decode of the state register plus mem_ready.
module multicycle_control
    import mc_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       pcwritecondne,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic [3:0] state,
    output logic       instr_done
);

    mc_state_t r_state;
    mc_state_t w_next;
    mc_ctrl_t  w_ctrl;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: w_next = decode_dispatch(opcode, funct);
            // IR is stable for the whole instruction, so opcode still
            // distinguishes lw from sw here.
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_REXEC:  w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_BNE, S_ADDIWB,
            S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
            default:  w_next = S_HALT;  // HALT is absorbing
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    mc_outdec u_outdec (
        .state     (r_state),
        .mem_ready (mem_ready),
        .reset     (reset),
        .ctrl      (w_ctrl)
    );

    assign state         = r_state;
    assign pcwrite       = w_ctrl.pcwrite;
    assign pcwritecond   = w_ctrl.pcwritecond;
    assign pcwritecondne = w_ctrl.pcwritecondne;
    assign iord          = w_ctrl.iord;
    assign memread       = w_ctrl.memread;
    assign memwrite      = w_ctrl.memwrite;
    assign irwrite       = w_ctrl.irwrite;
    assign regwrite      = w_ctrl.regwrite;
    assign alusrca       = w_ctrl.alusrca;
    assign regdst        = w_ctrl.regdst;
    assign memtoreg      = w_ctrl.memtoreg;
    assign alusrcb       = w_ctrl.alusrcb;
    assign aluop         = w_ctrl.aluop;
    assign pcsource      = w_ctrl.pcsource;
    assign instr_done    = w_ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    import mc_defs::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, pcwritecondne, iord, memread, memwrite;
    logic       irwrite, regwrite, alusrca, instr_done;
    logic [1:0] regdst, memtoreg, alusrcb, aluop, pcsource;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
        .pcwritecondne(pcwritecondne), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
        .state(state), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    logic [19:0] got_outs;
    logic [8:0]  got_strobes;
    assign got_outs = {pcwrite, pcwritecond, pcwritecondne, iord, memread, memwrite,
                       irwrite, regwrite, alusrca, regdst, memtoreg, alusrcb,
                       aluop, pcsource, instr_done};
    assign got_strobes = {pcwrite, pcwritecond, pcwritecondne, iord, memread,
                          memwrite, irwrite, regwrite, instr_done};

    // Output table taken straight from the per-state requirements.
    function automatic logic [19:0] exp_outs(input mc_state_t s, input logic mr);
        logic pw, pwc, pwn, io, mrd, mwr, irw, rw, asa, done;
        logic [1:0] rd, mtr, asb, aop, psrc;
        {pw, pwc, pwn, io, mrd, mwr, irw, rw, asa, done} = '0;
        {rd, mtr, asb, aop, psrc} = '0;
        case (s)
            S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            S_DECODE: begin asb = 2'b11; end
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mrd = 1; io = 1; end
            S_MEMWB:  begin rw = 1; mtr = 2'b01; done = 1; end
            S_MEMWR:  begin mwr = 1; io = 1; done = mr; end
            S_REXEC:  begin asa = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; rd = 2'b01; done = 1; end
            S_BEQ:    begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
            S_BNE:    begin asa = 1; aop = 2'b01; pwn = 1; psrc = 2'b01; done = 1; end
            S_ADDIEX: begin asa = 1; asb = 2'b10; end
            S_ADDIWB: begin rw = 1; done = 1; end
            S_JUMP:   begin pw = 1; psrc = 2'b10; done = 1; end
            S_JR:     begin pw = 1; psrc = 2'b11; done = 1; end
            S_JAL:    begin pw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; done = 1; end
            default:  ;
        endcase
        return {pw, pwc, pwn, io, mrd, mwr, irw, rw, asa, rd, mtr, asb, aop, psrc, done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // One clock cycle: drive mem_ready, compare state+outputs mid-cycle.
    task automatic step(input mc_state_t es, input logic mr, input string tag);
        mem_ready = mr;
        @(negedge clk);
        check(tag, {8'h0, state, got_outs}, {8'h0, es, exp_outs(es, mr)});
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        mc_state_t st;
        logic      mr;
    } sched_t;

    // Reference model: instruction class -> ordered phase list, with wait
    // cycles inserted wherever memory is involved.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw,
                             output int ncyc, output int nmw, output int done_at);
        mc_state_t path[$];
        sched_t    q[$];
        path = {S_FETCH, S_DECODE};
        if (op == 6'b100011)                      path = {path, S_MEMADR, S_MEMRD, S_MEMWB};
        else if (op == 6'b101011)                 path = {path, S_MEMADR, S_MEMWR};
        else if (op == 6'b000000 && fn == 6'b001000) path = {path, S_JR};
        else if (op == 6'b000000)                 path = {path, S_REXEC, S_RWB};
        else if (op == 6'b000100)                 path = {path, S_BEQ};
        else if (op == 6'b000101)                 path = {path, S_BNE};
        else if (op == 6'b001000)                 path = {path, S_ADDIEX, S_ADDIWB};
        else if (op == 6'b000010)                 path = {path, S_JUMP};
        else if (op == 6'b000011)                 path = {path, S_JAL};
        foreach (path[i]) begin
            if (path[i] == S_FETCH) begin
                for (int k = 0; k < fw; k++) q.push_back('{S_FETCH, 1'b0});
                q.push_back('{S_FETCH, 1'b1});
            end else if (path[i] == S_MEMRD || path[i] == S_MEMWR) begin
                for (int k = 0; k < mw; k++) q.push_back('{path[i], 1'b0});
                q.push_back('{path[i], 1'b1});
            end else begin
                q.push_back('{path[i], 1'($urandom_range(0, 1))});
            end
        end
        opcode = op;
        funct  = fn;
        ncyc = 0; nmw = 0; done_at = 0;
        foreach (q[i]) begin
            mem_ready = q[i].mr;
            @(negedge clk);
            ncyc++;
            if (memwrite) nmw++;
            if (instr_done) done_at = ncyc;
            check($sformatf("op%b_cyc%0d", op, ncyc), {8'h0, state, got_outs},
                  {8'h0, q[i].st, exp_outs(q[i].st, q[i].mr)});
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         len;
        mc_state_t  p2, p3, p4;
        string      name;
    } vec_t;

    function automatic mc_state_t vec_state(input vec_t v, input int c);
        case (c)
            0:       return S_FETCH;
            1:       return S_DECODE;
            2:       return v.p2;
            3:       return v.p3;
            default: return v.p4;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        mc_state_t es;
        int ncyc, nmw, done_at;
        logic [5:0] rop;
        logic [5:0] rfn;
        logic [5:0] ops[8];

        tbl[0] = '{6'b100011, 6'h00, 5, S_MEMADR, S_MEMRD, S_MEMWB, "lw"};
        tbl[1] = '{6'b101011, 6'h00, 4, S_MEMADR, S_MEMWR, S_HALT, "sw"};
        tbl[2] = '{6'b000000, 6'b100000, 4, S_REXEC, S_RWB, S_HALT, "rtype"};
        tbl[3] = '{6'b000000, 6'b001000, 3, S_JR, S_HALT, S_HALT, "jr"};
        tbl[4] = '{6'b000100, 6'h00, 3, S_BEQ, S_HALT, S_HALT, "beq"};
        tbl[5] = '{6'b000101, 6'h00, 3, S_BNE, S_HALT, S_HALT, "bne"};
        tbl[6] = '{6'b001000, 6'h00, 4, S_ADDIEX, S_ADDIWB, S_HALT, "addi"};
        tbl[7] = '{6'b000010, 6'h00, 3, S_JUMP, S_HALT, S_HALT, "j"};
        tbl[8] = '{6'b000011, 6'h00, 3, S_JAL, S_HALT, S_HALT, "jal"};

        reset = 1'b1; opcode = 6'b101011; funct = 6'h00; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_state", {28'h0, state}, {28'h0, S_FETCH});
            check("reset_strobes", {23'h0, got_strobes}, 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // Table vectors, zero wait states.
        for (int i = 0; i < 9; i++) begin
            v = tbl[i];
            opcode = v.op;
            funct  = v.fn;
            for (int c = 0; c < v.len; c++) begin
                es = vec_state(v, c);
                mem_ready = 1'b1;
                @(negedge clk);
                check($sformatf("%s_state%0d", v.name, c), {28'h0, state}, {28'h0, es});
                check($sformatf("%s_outs%0d", v.name, c), {12'h0, got_outs}, {12'h0, exp_outs(es, 1'b1)});
                check($sformatf("%s_done%0d", v.name, c), {31'h0, instr_done}, {31'h0, (c == v.len - 1)});
                @(posedge clk);
                #1;
            end
        end

        // Store with three memory wait cycles.
        run_instr(6'b101011, 6'h00, 0, 3, ncyc, nmw, done_at);
        check("sw_wait_memwrite_cycles", nmw, 4);
        check("sw_wait_done_cycle", done_at, 7);
        check("sw_wait_len", ncyc, 7);

        // Load with fetch and read waits.
        run_instr(6'b100011, 6'h00, 2, 2, ncyc, nmw, done_at);
        check("lw_wait_len", ncyc, 9);
        check("lw_wait_done_cycle", done_at, 9);

        // Unknown opcode halts and stays quiet until reset.
        opcode = 6'b111111;
        step(S_FETCH, 1'b1, "halt_fetch");
        step(S_DECODE, 1'b1, "halt_decode");
        for (int i = 0; i < 10; i++) step(S_HALT, 1'($urandom_range(0, 1)), $sformatf("halt_%0d", i));
        reset = 1'b1;
        #1;
        check("halt_reset_state", {28'h0, state}, {28'h0, S_FETCH});
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(6'b000010, 6'h00, 0, 0, ncyc, nmw, done_at);
        check("after_halt_j_len", ncyc, 3);

        // Reset between edges during a store wait.
        opcode = 6'b101011;
        step(S_FETCH, 1'b1, "abort_fetch");
        step(S_DECODE, 1'b1, "abort_decode");
        step(S_MEMADR, 1'b1, "abort_memadr");
        mem_ready = 1'b0;
        @(negedge clk);
        check("abort_memwrite_before", {31'h0, memwrite}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("abort_memwrite_after", {31'h0, memwrite}, 32'h0);
        check("abort_state", {28'h0, state}, {28'h0, S_FETCH});
        check("abort_strobes", {23'h0, got_strobes}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(S_FETCH, 1'b0, "abort_refetch_wait");
        run_instr(6'b100011, 6'h00, 0, 0, ncyc, nmw, done_at);
        check("abort_recover_lw_done", done_at, 5);

        // Randomized instruction stream against the reference model.
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b000010, 6'b000011};
        for (int n = 0; n < 60; n++) begin
            rop = ops[$urandom_range(0, 7)];
            rfn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
            run_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 3), ncyc, nmw, done_at);
            check($sformatf("rand%0d_done_last", n), done_at, ncyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
